// File: rtl/con_pkg.sv
// Shared types and constants for the controller poll scheduler.
// Holds the scheduler state enum, word width and SNES button bit positions.
package con_pkg;

  localparam int CON_WORD_W = 16;

  // SNES shift order: bit 0 is the first bit clocked out of the pad.
  localparam int CON_BTN_B      = 0;
  localparam int CON_BTN_Y      = 1;
  localparam int CON_BTN_SELECT = 2;
  localparam int CON_BTN_START  = 3;
  localparam int CON_BTN_UP     = 4;
  localparam int CON_BTN_DOWN   = 5;
  localparam int CON_BTN_LEFT   = 6;
  localparam int CON_BTN_RIGHT  = 7;
  localparam int CON_BTN_A      = 8;
  localparam int CON_BTN_X      = 9;
  localparam int CON_BTN_L      = 10;
  localparam int CON_BTN_R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STORE  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_COMMIT = 3'd5
  } con_sched_state_t;

endpackage

// File: rtl/con_edge_det.sv
// Per-port sticky "newly pressed" register, used only when CON_EDGE_EN is defined.
// Edges accumulate at each frame commit and clear when software reads the port.
module con_edge_det
  import con_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  commit,
  input  logic                  clr,
  input  logic                  new_present,
  input  logic [CON_WORD_W-1:0] new_word,
  input  logic [CON_WORD_W-1:0] old_word,
  output logic [CON_WORD_W-1:0] pressed
);

  // A read clearing in the commit cycle drops only the old edges; fresh edges survive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pressed <= '0;
    end else if (commit) begin
      if (!new_present) pressed <= '0;
      else              pressed <= (clr ? '0 : pressed) | (new_word & ~old_word);
    end else if (clr) begin
      pressed <= '0;
    end
  end

endmodule

// File: rtl/con_poll_sched.sv
// Poll scheduler: time-multiplexes one SNES engine across NUM_PORTS pads per tick,
// commits whole-frame snapshots and serves req/ack reads. Optional edge flags: CON_EDGE_EN.
//
// Read handshake: rd_req is a level sampled every cycle; when rd_req is high and
// rd_ack was low last cycle, rd_ack pulses the next cycle with rd_data (and
// rd_pressed) for rd_port. rd_data holds between acks.
module con_poll_sched
  import con_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int POLL_PERIOD = 833333,
  parameter int ENG_TIMEOUT = 16384
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  eng_start,
  output logic [1:0]            eng_sel,
  input  logic                  eng_done,
  input  logic [CON_WORD_W-1:0] eng_word,
  input  logic                  rd_req,
  input  logic [1:0]            rd_port,
  output logic                  rd_ack,
  output logic [CON_WORD_W-1:0] rd_data,
`ifdef CON_EDGE_EN
  output logic [CON_WORD_W-1:0] rd_pressed,
`endif
  output logic [NUM_PORTS-1:0]  present,
  output logic                  frame_tick,
  output logic [7:0]            overrun_cnt,
  output con_sched_state_t      dbg_state
);

  localparam int TW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TOW = $clog2(ENG_TIMEOUT + 1);

  con_sched_state_t state_q, state_d;
  logic [1:0]            port_q, port_d;
  logic [TW-1:0]         timer_q;
  logic [TOW-1:0]        to_cnt_q;
  logic                  to_flag_q, to_flag_d;
  logic                  tick;
  logic [CON_WORD_W-1:0] word_q;
  logic [CON_WORD_W-1:0] shadow   [NUM_PORTS];
  logic [CON_WORD_W-1:0] snapshot [NUM_PORTS];
  logic [NUM_PORTS-1:0]  shadow_pres;
  logic [CON_WORD_W-1:0] rd_word;
  logic                  ack_fire;

  assign tick      = (timer_q == TW'(POLL_PERIOD - 1));
  assign eng_sel   = port_q;
  assign dbg_state = state_q;
  assign ack_fire  = rd_req && !rd_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timer_q <= '0;
    else if (tick) timer_q <= '0;
    else timer_q <= timer_q + TW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      port_q    <= '0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      to_flag_q <= to_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    to_flag_d  = to_flag_q;
    eng_start  = 1'b0;
    frame_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          port_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        eng_start = 1'b1;
        to_flag_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d = ST_STORE;
        end else if (to_cnt_q == TOW'(ENG_TIMEOUT - 1)) begin
          to_flag_d = 1'b1;
          state_d   = ST_STORE;
        end
      end
      ST_STORE: state_d = ST_NEXT;
      ST_NEXT: begin
        if (port_q == 2'(NUM_PORTS - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          port_d  = port_q + 2'd1;
          state_d = ST_START;
        end
      end
      ST_COMMIT: begin
        frame_tick = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // eng_word is only valid on the done pulse, so hold it for the STORE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      word_q   <= '0;
    end else begin
      if (state_q == ST_START) to_cnt_q <= '0;
      else if (state_q == ST_WAIT) to_cnt_q <= to_cnt_q + TOW'(1);
      if (state_q == ST_WAIT && eng_done) word_q <= eng_word;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shadow[i]   <= '0;
        snapshot[i] <= '0;
      end
      shadow_pres <= '0;
      present     <= '0;
    end else begin
      if (state_q == ST_STORE) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (port_q == 2'(i)) begin
            shadow[i]      <= to_flag_q ? '0 : word_q;
            shadow_pres[i] <= !to_flag_q;
          end
        end
      end
      if (state_q == ST_COMMIT) begin
        for (int i = 0; i < NUM_PORTS; i++) snapshot[i] <= shadow[i];
        present <= shadow_pres;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overrun_cnt <= '0;
    else if (tick && state_q != ST_IDLE && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  // Out-of-range ports read as zero but are still acknowledged.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (rd_port == 2'(i)) rd_word = snapshot[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= ack_fire;
      if (ack_fire) rd_data <= rd_word;
    end
  end

`ifdef CON_EDGE_EN
  logic [CON_WORD_W-1:0] pressed [NUM_PORTS];
  logic [NUM_PORTS-1:0]  clr_vec;
  logic [CON_WORD_W-1:0] rd_press_word;

  always_comb begin
    clr_vec       = '0;
    rd_press_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_port == 2'(i)) begin
        clr_vec[i]    = ack_fire;
        rd_press_word = pressed[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_edge
    con_edge_det u_edge (
      .clock       (clock),
      .reset       (reset),
      .commit      (state_q == ST_COMMIT),
      .clr         (clr_vec[g]),
      .new_present (shadow_pres[g]),
      .new_word    (shadow[g]),
      .old_word    (snapshot[g]),
      .pressed     (pressed[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_pressed <= '0;
    else if (ack_fire) rd_pressed <= rd_press_word;
  end
`endif

endmodule

// File: doc/con_poll_sched.md
Name: con_poll_sched

Overview:
- Scheduler between the 60 Hz controller poll and software.
- Owns one shared SNES protocol engine (latch/clock/serial) and time-multiplexes it across NUM_PORTS controller ports on each poll tick.
- Collects per-port 16-bit button words and commits them atomically as one frame snapshot.
- Serves CPU/IOSS register reads with a req/ack handshake.
- Sits between the protocol engine and the IOSS register file.

Parameters:
- NUM_PORTS, 2, number of controller ports sharing the engine (1..4).
- POLL_PERIOD, 833333, clock cycles between poll rounds (60 Hz at 50 MHz).
- ENG_TIMEOUT, 16384, cycles allowed from eng_start to eng_done before the port is declared absent.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- eng_start  out  1  one-cycle pulse; engine begins one latch/16-clock transaction
- eng_sel  out  2  port whose serial/latch lines the engine uses; stable from eng_start until eng_done
- eng_done  in  1  one-cycle pulse; eng_word is valid
- eng_word  in  16  button word from the engine
- rd_req  in  1  level; CPU read request
- rd_port  in  2  port to read; sampled with rd_req
- rd_ack  out  1  one-cycle pulse
- rd_data  out  16  snapshot word for rd_port
- present  out  NUM_PORTS  per-port connected flag from the last committed frame
- frame_tick  out  1  one-cycle pulse on snapshot commit
- overrun_cnt  out  8  saturating count of poll ticks dropped while a round was in progress

Behaviour:
- Reset values: all outputs 0; snapshot, shadow and present registers 0; FSM in IDLE; port index 0.
- Internal POLL_PERIOD timer:
  - Free-runs from reset.
  - Wraps to 0 at POLL_PERIOD-1 and pulses tick on the wrap.
- FSM states IDLE, START, WAIT, STORE, NEXT, COMMIT:
  - IDLE: on tick, port index = 0 and go to START.
  - START: assert eng_start for exactly 1 cycle, clear the timeout counter, go to WAIT.
  - WAIT: on eng_done, go to STORE. Otherwise, when the timeout counter reaches ENG_TIMEOUT-1, go to STORE with the timeout flag set.
  - STORE:
    - Normal: shadow[port] = eng_word, shadow_present[port] = 1.
    - On timeout: shadow[port] = 16'h0000, shadow_present[port] = 0.
    - Go to NEXT.
  - NEXT: if port == NUM_PORTS-1, go to COMMIT; otherwise port+1, go to START.
  - COMMIT: copy shadow into snapshot and shadow_present into present in one cycle, pulse frame_tick, go to IDLE.
- eng_sel equals the port index in every state. eng_done outside WAIT is ignored.
- Tick arriving in any state other than IDLE:
  - The round continues; it is neither restarted nor queued.
  - overrun_cnt increments, saturating at 8'hFF.
- Round latency: 2 + NUM_PORTS*(3 + engine cycles) cycles from tick to frame_tick.
- Read handshake:
  - rd_req is sampled each cycle. When rd_req is high and rd_ack was low the previous cycle, the next cycle asserts rd_ack with rd_data = snapshot[rd_port].
  - A held rd_req yields one ack every other cycle.
  - rd_port >= NUM_PORTS returns 16'h0000 and is still acked.
- Read and COMMIT in the same cycle: rd_data returns the pre-commit snapshot. Tearing across ports is impossible because software only ever sees whole frames.
- rd_data holds its value between acks.
- Reset asserted mid-round: the FSM returns to IDLE, eng_start is deasserted immediately, and the partial shadow is discarded. The engine must tolerate an abandoned transaction.

Optional Feature:
- Macro CON_EDGE_EN.
- With the macro defined:
  - Per-port 16-bit sticky pressed register, set at COMMIT with new & ~old snapshot bits.
  - An ack on port p returns snapshot in rd_data and the pressed flags on an added output rd_pressed[15:0], then clears pressed[p].
  - If a commit and a clear hit the same port in the same cycle, the new edges are kept and the old edges are cleared.
  - A port whose present flag falls to 0 gets its pressed flags cleared.
- Without the macro: no edge logic, no rd_pressed port.

Decomposition:
- Shared package con_pkg:
  - state enum con_sched_state_t.
  - constant CON_WORD_W = 16.
  - button bit index constants (B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R).
- One natural sub-module: con_edge_det, the per-port sticky edge register. It is instantiated only under CON_EDGE_EN.

Test Plan:
- NUM_PORTS=2, POLL_PERIOD=1000, engine model returns 16'h0A5F for port 0 and 16'h8001 for port 1 -> one frame_tick per 1000 cycles; reads return 0A5F and 8001; present = 2'b11.
- Port 1 never pulses eng_done -> after ENG_TIMEOUT cycles the commit gives snapshot[1] = 0 and present = 2'b01; port 0 is unaffected.
- Engine stretched to 1200 cycles per transaction -> overrun_cnt increments once per dropped tick and reaches 8'hFF after 255+ drops, then holds.
- rd_req in the exact COMMIT cycle with the old value 16'h0000 and the new value 16'h0010 -> rd_data = 16'h0000; the next read returns 16'h0010.
- Reset pulled low during WAIT of port 1 -> all outputs 0 the next cycle; after reset the first frame is correct and no stale port-0 data is committed.
- With CON_EDGE_EN, word 0000 -> 0101 -> 0101 -> first read rd_pressed = 0101, second read rd_pressed = 0000.
